// File: rtl/des_word_packer.sv
// Packs four synchronized bus words into a DES data block and key, holding the
// result in a single valid/ready output register with frame watchdog and overflow flag.
module des_word_packer #(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [BUS_WIDTH-1:0]   sync_bus,
    input  logic                   word_strobe,
    output logic [2*BUS_WIDTH-1:0] blk_data,
    output logic [2*BUS_WIDTH-1:0] blk_key,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   busy,
    output logic                   timeout_pulse,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // The watchdog fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] sh0_q, sh1_q, sh2_q;
    logic                 last_word, out_free, load_blk, drop_blk, expire;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        expire    = 1'b0;
        last_word = word_strobe && (idx_q == 2'd3);
        out_free  = !blk_valid || blk_ready;
        load_blk  = last_word && out_free;
        drop_blk  = last_word && !out_free;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (word_strobe) begin
                    idx_d   = 2'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (word_strobe) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            timeout_pulse <= expire;
        end
    end

    // Shadow words w0..w2; w3 goes straight from the bus into the output register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the shadow words are reset too, so an abandoned frame can never leak stale contents.
            sh0_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
        end else if (word_strobe) begin
            case (idx_q)
                2'd0:    sh0_q <= sync_bus;
                2'd1:    sh1_q <= sync_bus;
                2'd2:    sh2_q <= sync_bus;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            blk_data  <= '0;
            blk_key   <= '0;
            blk_valid <= 1'b0;
        end else if (load_blk) begin
            blk_data  <= {sh0_q, sh1_q};
            blk_key   <= {sh2_q, sync_bus};
            blk_valid <= 1'b1;
        end else if (blk_valid && blk_ready) begin
            blk_valid <= 1'b0;
        end
    end

    // A new drop outranks a clear issued in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          overflow <= 1'b0;
        else if (drop_blk) overflow <= 1'b1;
        else if (ovf_clr)  overflow <= 1'b0;
    end

    assign busy = (state_q == COLLECT);

endmodule

// File: tb/tb_des_word_packer.sv
// Self-checking bench for des_word_packer: directed scenarios plus a randomized
// run compared cycle by cycle against a frame-level reference model.
module tb_des_word_packer;

    localparam int W  = 32;
    localparam int T  = 255;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [W-1:0]  sync_bus = '0;
    logic          word_strobe = 1'b0;
    logic          blk_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [2*W-1:0] blk_data, blk_key;
    logic          blk_valid, busy, timeout_pulse, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the words collected so far, idle cycles since the last word, held block.
    logic [W-1:0]   m_words[$];
    int             m_idle;
    logic           m_hv, m_ovf, m_tp;
    logic [2*W-1:0] m_hd, m_hk;

    des_word_packer #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .sync_bus(sync_bus), .word_strobe(word_strobe),
        .blk_data(blk_data), .blk_key(blk_key), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .busy(busy), .timeout_pulse(timeout_pulse), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_words.delete();
        m_idle = 0;
        m_hv = 1'b0; m_ovf = 1'b0; m_tp = 1'b0;
        m_hd = '0;   m_hk = '0;
    endtask

    task automatic model_edge(input logic s, input logic [W-1:0] b, input logic r, input logic c);
        logic loaded, ovf_set;
        loaded = 1'b0; ovf_set = 1'b0; m_tp = 1'b0;
        if (s) begin
            m_idle = 0;
            if (m_words.size() == 3) begin
                if (!m_hv || r) begin
                    m_hd = {m_words[0], m_words[1]};
                    m_hk = {m_words[2], b};
                    loaded = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
                m_words.delete();
            end else begin
                m_words.push_back(b);
            end
        end else if (m_words.size() != 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_words.delete();
                m_idle = 0;
                m_tp = 1'b1;
            end
        end
        if (loaded) m_hv = 1'b1;
        else if (r) m_hv = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
        else if (c)  m_ovf = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model and returns #1 after the edge.
    task automatic cycle(input logic s, input logic [W-1:0] b, input logic r, input logic c);
        word_strobe = s; sync_bus = b; blk_ready = r; ovf_clr = c;
        model_edge(s, b, r, c);
        @(posedge CLK); #1;
        word_strobe = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        model_reset();
        @(posedge CLK); @(posedge CLK); #1;
        n_cmp++; if (blk_data !== '0)      begin n_bad++; $display("FAIL reset_data: got %h want 0", blk_data); end
        n_cmp++; if (blk_key !== '0)       begin n_bad++; $display("FAIL reset_key: got %h want 0", blk_key); end
        n_cmp++; if (blk_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid: got %b want 0", blk_valid); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (timeout_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_tp: got %b want 0", timeout_pulse); end
        n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        #3 RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] w[4];
        w[0] = 32'h01234567; w[1] = 32'h89ABCDEF; w[2] = 32'h13345779; w[3] = 32'h9BBCDFF1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, w[i], 1'b1, 1'b0);
            if (i == 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
            end
            if (i < 3) cycle(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", blk_valid); end
        n_cmp++; if (blk_data !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL basic_data: got %h want 0123456789abcdef", blk_data); end
        n_cmp++; if (blk_key !== 64'h133457799BBCDFF1) begin n_bad++; $display("FAIL basic_key: got %h want 133457799bbcdff1", blk_key); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b want 0", busy); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL basic_fall: got %b want 0", blk_valid); end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] a[4], b[4];
        for (int i = 0; i < 4; i++) begin a[i] = $urandom; b[i] = $urandom; end
        for (int i = 0; i < 4; i++) cycle(1'b1, a[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            cycle(1'b1, b[i], 1'b0, 1'b0);
            n_cmp++; if (blk_data !== {a[0], a[1]} || blk_key !== {a[2], a[3]} || blk_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold: got v=%b %h/%h want v=1 %h/%h", blk_valid, blk_data, blk_key, {a[0], a[1]}, {a[2], a[3]});
            end
        end
        cycle(1'b1, b[3], 1'b1, 1'b0);
        n_cmp++; if (blk_data !== {b[0], b[1]} || blk_key !== {b[2], b[3]} || blk_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_frame_b: got v=%b %h/%h want v=1 %h/%h", blk_valid, blk_data, blk_key, {b[0], b[1]}, {b[2], b[3]});
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf: got %b want 0", overflow); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", blk_valid); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] f1[4], f2[4];
        for (int i = 0; i < 4; i++) begin f1[i] = $urandom; f2[i] = $urandom; end
        for (int i = 0; i < 4; i++) cycle(1'b1, f1[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
            cycle(1'b0, '0, 1'b0, 1'b0);
            cycle(1'b1, f2[i], 1'b0, 1'b0);
        end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++; if (blk_data !== {f1[0], f1[1]} || blk_key !== {f1[2], f1[3]}) begin
            n_bad++; $display("FAIL ovf_retain: got %h/%h want %h/%h", blk_data, blk_key, {f1[0], f1[1]}, {f1[2], f1[3]});
        end
        n_cmp++; if (busy !== 1'b0 || blk_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_state: got busy=%b v=%b want busy=0 v=1", busy, blk_valid); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        // A clear coinciding with a fresh drop must leave the flag set.
        for (int i = 0; i < 3; i++) cycle(1'b1, f2[i], 1'b0, 1'b0);
        cycle(1'b1, f2[3], 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_vs_set: got %b want 1", overflow); end
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (overflow !== 1'b0 || blk_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got ovf=%b v=%b want 0 0", overflow, blk_valid); end
    endtask

    task automatic test_timeout();
        logic [W-1:0] w[4];
        logic exp_tp, exp_busy;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        cycle(1'b1, w[0], 1'b1, 1'b0);
        cycle(1'b1, w[1], 1'b1, 1'b0);
        n_cmp++; if (timeout_pulse !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_start: got tp=%b busy=%b want 0 1", timeout_pulse, busy); end
        for (int j = 2; j <= T + 1; j++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            exp_tp = (j == T + 1);
            exp_busy = (j <= T);
            n_cmp++; if (timeout_pulse !== exp_tp || busy !== exp_busy) begin
                n_bad++; $display("FAIL to_wait[%0d]: got tp=%b busy=%b want tp=%b busy=%b", j, timeout_pulse, busy, exp_tp, exp_busy);
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (timeout_pulse !== 1'b0) begin n_bad++; $display("FAIL to_one_cycle: got %b want 0", timeout_pulse); end
        for (int i = 0; i < 4; i++) cycle(1'b1, w[3-i], 1'b1, 1'b0);
        n_cmp++; if (blk_data !== {w[3], w[2]} || blk_key !== {w[1], w[0]} || blk_valid !== 1'b1) begin
            n_bad++; $display("FAIL to_next_frame: got v=%b %h/%h want v=1 %h/%h", blk_valid, blk_data, blk_key, {w[3], w[2]}, {w[1], w[0]});
        end
        // A strobe on the expiry cycle keeps the frame alive.
        cycle(1'b1, w[0], 1'b1, 1'b0);
        cycle(1'b1, w[1], 1'b1, 1'b0);
        for (int j = 2; j <= T; j++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, w[2], 1'b1, 1'b0);
        n_cmp++; if (timeout_pulse !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_strobe_wins: got tp=%b busy=%b want 0 1", timeout_pulse, busy); end
        cycle(1'b1, w[3], 1'b1, 1'b0);
        n_cmp++; if (blk_data !== {w[0], w[1]} || blk_key !== {w[2], w[3]} || blk_valid !== 1'b1) begin
            n_bad++; $display("FAIL to_late_frame: got v=%b %h/%h want v=1 %h/%h", blk_valid, blk_data, blk_key, {w[0], w[1]}, {w[2], w[3]});
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] p[4], q[4];
        for (int i = 0; i < 4; i++) begin p[i] = $urandom; q[i] = $urandom; end
        for (int i = 0; i < 4; i++) cycle(1'b1, p[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, q[i], (i == 3), 1'b0);
            n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, blk_valid); end
        end
        n_cmp++; if (blk_data !== {q[0], q[1]} || blk_key !== {q[2], q[3]}) begin
            n_bad++; $display("FAIL b2b_frame: got %h/%h want %h/%h", blk_data, blk_key, {q[0], q[1]}, {q[2], q[3]});
        end
        n_cmp++; if (overflow !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_state: got ovf=%b busy=%b want 0 0", overflow, busy); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, w[0], 1'b0, 1'b0);
        cycle(1'b1, w[1], 1'b0, 1'b0);
        n_cmp++; if (blk_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got v=%b busy=%b want 1 1", blk_valid, busy); end
        #2 RST = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (blk_data !== '0 || blk_key !== '0) begin n_bad++; $display("FAIL ar_block: got %h/%h want 0/0", blk_data, blk_key); end
        n_cmp++; if (blk_valid !== 1'b0 || busy !== 1'b0 || timeout_pulse !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL ar_flags: got v=%b busy=%b tp=%b ovf=%b want all 0", blk_valid, busy, timeout_pulse, overflow);
        end
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
        n_cmp++; if (blk_data !== {w[0], w[1]} || blk_key !== {w[2], w[3]} || blk_valid !== 1'b1) begin
            n_bad++; $display("FAIL ar_fresh: got v=%b %h/%h want v=1 %h/%h", blk_valid, blk_data, blk_key, {w[0], w[1]}, {w[2], w[3]});
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic s, r, c;
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                for (int k = 0; k < T + 3; k++) begin
                    cycle(1'b0, '0, 1'b1, 1'b0);
                    n_cmp++; if (timeout_pulse !== m_tp || busy !== (m_words.size() != 0)) begin
                        n_bad++; $display("FAIL rnd_quiet[%0d]: got tp=%b busy=%b want tp=%b busy=%b", k, timeout_pulse, busy, m_tp, (m_words.size() != 0));
                    end
                end
            end
            cycle(s, $urandom, r, c);
            n_cmp++; if (blk_valid !== m_hv) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, blk_valid, m_hv); end
            n_cmp++; if (m_hv && (blk_data !== m_hd || blk_key !== m_hk)) begin
                n_bad++; $display("FAIL rnd_block[%0d]: got %h/%h want %h/%h", n, blk_data, blk_key, m_hd, m_hk);
            end
            n_cmp++; if (busy !== (m_words.size() != 0)) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, (m_words.size() != 0)); end
            n_cmp++; if (timeout_pulse !== m_tp) begin n_bad++; $display("FAIL rnd_tp[%0d]: got %b want %b", n, timeout_pulse, m_tp); end
            n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, overflow, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/des_word_packer.md
# des_word_packer

Destination-domain stage directly downstream of the CDC data synchronizer. It consumes the synchronized 32-bit word bus and its one-cycle strobe, assembles four consecutive words into a 64-bit data block and a 64-bit key, and presents them to the DES core over a valid/ready handshake. A single output holding register decouples collection from the core's back-pressure. A watchdog discards partial frames, and an overflow detector flags complete frames that are lost.

## Interface
- BUS_WIDTH, 32, width of one synchronized word; block and key widths are 2*BUS_WIDTH
- TIMEOUT_CYCLES, 255, idle cycles allowed between words of a partial frame before it is discarded (≥2)
- CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

- CLK  in  1  destination-domain clock
- RST  in  1  asynchronous, active-low reset
- sync_bus  in  BUS_WIDTH  synchronized word, valid in the cycle word_strobe is high
- word_strobe  in  1  one-cycle strobe per word; driven by the synchronizer's delayed enable pulse
- blk_data  out  2*BUS_WIDTH  assembled data block
- blk_key  out  2*BUS_WIDTH  assembled key
- blk_valid  out  1  output register holds an unconsumed block
- blk_ready  in  1  DES core accepts the block when blk_valid && blk_ready
- busy  out  1  partial frame in progress (word index ≠ 0)
- timeout_pulse  out  1  one-cycle pulse when a partial frame is discarded
- overflow  out  1  sticky; a complete frame was dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Word order within a frame:
  - w0 → data[2W-1:W]
  - w1 → data[W-1:0]
  - w2 → key[2W-1:W]
  - w3 → key[W-1:0]
- Words w0–w2 go to shadow registers. The word index (0–3) advances on each strobe and wraps 3→0 on w3.
- States: IDLE (idx=0) and COLLECT (idx 1–3). busy = COLLECT.
- On the w3 strobe, the output register is free if blk_valid=0 or blk_valid && blk_ready in the same cycle.
  - Free: load blk_data = {shadow w0, shadow w1}, blk_key = {shadow w2, sync_bus}; set blk_valid.
  - Not free: drop the frame, set overflow. The output register is left untouched. idx returns to 0.
- Handshake:
  - blk_valid falls the cycle after a transfer unless a new frame is loaded in that same cycle; in that case it stays high.
  - blk_data and blk_key stay stable while blk_valid && !blk_ready.
- Watchdog:
  - The counter clears on every strobe and while in IDLE. It increments each non-strobe cycle in COLLECT.
  - When it reaches TIMEOUT_CYCLES: idx → 0, shadow contents abandoned, timeout_pulse asserted for one cycle, counter cleared.
- Simultaneous events:
  - A strobe in the cycle the watchdog would expire wins: the word is accepted and the counter clears.
  - ovf_clr and a new overflow in the same cycle: overflow is set.
- Strobes are assumed ≥1 cycle apart. Back-to-back strobes on consecutive cycles must still be accepted one word per cycle.

## Timing
- All outputs registered. Reset values: blk_data 0, blk_key 0, blk_valid 0, busy 0, timeout_pulse 0, overflow 0. Internal idx and counter are also reset to 0.
- Reset is asynchronous mid-frame: the partial frame is lost, and any held block is lost with blk_valid forced to 0.
- Latency: w3 strobe at cycle N → blk_valid = 1 and block visible at N+1.
- Overflow is set at N+1 after a dropped w3.
- Timeout: last strobe at cycle N → timeout_pulse at N+TIMEOUT_CYCLES+1, and busy = 0 from that same cycle.
- Throughput: one frame per 4 strobes. The core may hold blk_ready low for up to 3 strobe intervals without loss.

## Test plan
- Reset, then strobe words 0x01234567, 0x89ABCDEF, 0x13345779, 0x9BBCDFF1 with blk_ready=1 → one cycle after the 4th strobe, blk_valid=1, blk_data=0x0123456789ABCDEF, blk_key=0x133457799BBCDFF1; blk_valid falls the next cycle.
- Back-pressure: blk_ready=0, send frame A then 3 words of B, raise blk_ready, send B's w3 → A transfers intact; B appears one cycle after its w3 strobe; overflow stays 0.
- Overflow: blk_ready=0 held through two full frames → blk_data retains frame 1; overflow=1 one cycle after frame 2's w3; busy=0. Pulse ovf_clr → overflow=0.
- Timeout with TIMEOUT_CYCLES=255: send 2 words, then idle → timeout_pulse at cycle 256 after the last strobe, busy=0. The next 4 words form a correct frame. Also drive a strobe exactly at cycle 255 → no timeout, word accepted.
- Asynchronous reset asserted mid-frame (idx=2) and while blk_valid=1 → all outputs 0 immediately. After release, a fresh 4-word frame assembles correctly.
- Back-to-back strobes on 4 consecutive cycles while blk_valid && blk_ready from a previous frame → new block loaded with no bubble; blk_valid stays high.
